// File: rtl/sram_access_arbiter.sv
// N-channel request arbiter onto one single-port SRAM, with read-data return
// routing and an exclusive channel-0 update mode that drains in-flight reads first.
module sram_access_arbiter #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iUpdateFlag,
    input  logic [NUM_CH-1:0]    iReq,
    input  logic [NUM_CH-1:0]    iWrn,
    input  logic [NUM_CH*AW-1:0] iAddr,
    input  logic [NUM_CH*DW-1:0] iWrDt,
    output logic [NUM_CH-1:0]    oGnt,
    output logic                 oCsn_Mux,
    output logic                 oWrn_Mux,
    output logic [AW-1:0]        oAddr_Mux,
    output logic [DW-1:0]        oWrDt_Mux,
    input  logic [DW-1:0]        iRdDt,
    output logic [DW-1:0]        oRdDt,
    output logic [NUM_CH-1:0]    oRdVld,
    output logic                 oUpdBusy
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] req_elig;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     base;
    logic [CW:0]       cand;
    logic              gnt_any;
    logic [CW-1:0]     gnt_idx;

    // Read tag of the command on the bus, then RD_LAT stages until data returns
    logic              cmd_rd_vld;
    logic [CW-1:0]     cmd_rd_ch;
    logic [RD_LAT-1:0] tag_vld;
    logic [CW-1:0]     tag_ch [RD_LAT];
    logic              pipe_empty;

    assign pipe_empty = !cmd_rd_vld && (tag_vld == '0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_NORMAL: if (iUpdateFlag) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!iUpdateFlag) begin
                    state_nxt = ST_NORMAL;
                end else if (pipe_empty) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: if (!iUpdateFlag) state_nxt = ST_NORMAL;
            default:   state_nxt = ST_NORMAL;
        endcase
    end

    // No grants on the cycle the flag is first seen or the cycle it drops
    always_comb begin
        eligible = '0;
        oUpdBusy = 1'b0;
        case (state)
            ST_NORMAL: if (!iUpdateFlag) eligible = '1;
            ST_DRAIN:  oUpdBusy = 1'b1;
            ST_UPDATE: begin
                oUpdBusy = 1'b1;
                if (iUpdateFlag) eligible[0] = 1'b1;
            end
            default: eligible = '0;
        endcase
        if (iRst) eligible = '0;
    end

    assign req_elig = iReq & eligible;
    assign base     = (ARB_MODE == 1) ? rr_ptr : '0;

    // Circular search from base; base is 0 in fixed-priority mode
    always_comb begin
        oGnt    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (CW+1)'(base) + (CW+1)'(i);
            if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
            if (!gnt_any && req_elig[cand[CW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[CW-1:0];
            end
        end
        if (gnt_any) oGnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oCsn_Mux   <= 1'b1;
            oWrn_Mux   <= 1'b1;
            oAddr_Mux  <= '0;
            oWrDt_Mux  <= '0;
            cmd_rd_vld <= 1'b0;
            cmd_rd_ch  <= '0;
            rr_ptr     <= '0;
        end else begin
            oCsn_Mux   <= !gnt_any;
            oWrn_Mux   <= gnt_any ? iWrn[gnt_idx] : 1'b1;
            cmd_rd_vld <= gnt_any && iWrn[gnt_idx];
            cmd_rd_ch  <= gnt_idx;
            if (gnt_any) begin
                oAddr_Mux <= iAddr[32'(gnt_idx)*AW +: AW];
                oWrDt_Mux <= iWrDt[32'(gnt_idx)*DW +: DW];
            end
            // Pointer is frozen while channel 0 owns the SRAM
            if (gnt_any && state == ST_NORMAL) begin
                rr_ptr <= (gnt_idx == CW'(NUM_CH-1)) ? '0 : gnt_idx + CW'(1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            tag_vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_ch[i] <= '0;
            oRdVld <= '0;
            oRdDt  <= '0;
        end else begin
            tag_vld[0] <= cmd_rd_vld;
            tag_ch[0]  <= cmd_rd_ch;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_ch[i]  <= tag_ch[i-1];
            end
            oRdVld <= '0;
            if (tag_vld[RD_LAT-1]) begin
                oRdVld[tag_ch[RD_LAT-1]] <= 1'b1;
                oRdDt                    <= iRdDt;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: three configurations (round-robin RD_LAT=1,
// fixed-priority RD_LAT=1, round-robin RD_LAT=3) checked against a cycle model.
module tb_sram_access_arbiter;
    localparam int NI = 3;
    localparam int M_NORM = 0;
    localparam int M_DRAIN = 1;
    localparam int M_UPD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flag;
    logic [2:0]  req;
    logic [2:0]  wrn;
    logic [11:0] addr;
    logic [47:0] wrdt;

    logic [NI-1:0][2:0]  gnt;
    logic [NI-1:0]       csn;
    logic [NI-1:0]       wrnm;
    logic [NI-1:0][3:0]  addrm;
    logic [NI-1:0][15:0] wrdtm;
    logic [NI-1:0][15:0] rdin;
    logic [NI-1:0][15:0] rddt;
    logic [NI-1:0][2:0]  rdvld;
    logic [NI-1:0]       busy;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    function automatic logic [15:0] init_word(input int a);
        return (a == 10) ? 16'h1234 : 16'(16'hC000 + a * 16'h0111);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT  = (g == 2) ? 3 : 1;
        localparam int unsigned MODE = (g == 1) ? 0 : 1;
        logic [15:0] mem [16];
        logic [15:0] dly [LAT];

        sram_access_arbiter #(
            .NUM_CH(3), .AW(4), .DW(16), .RD_LAT(LAT), .ARB_MODE(MODE)
        ) u_dut (
            .iClk(clk), .iRst(rst), .iUpdateFlag(flag),
            .iReq(req), .iWrn(wrn), .iAddr(addr), .iWrDt(wrdt),
            .oGnt(gnt[g]), .oCsn_Mux(csn[g]), .oWrn_Mux(wrnm[g]),
            .oAddr_Mux(addrm[g]), .oWrDt_Mux(wrdtm[g]),
            .iRdDt(rdin[g]), .oRdDt(rddt[g]), .oRdVld(rdvld[g]),
            .oUpdBusy(busy[g])
        );

        // SRAM: data for a bus read in cycle c is presented during c+LAT
        always @(posedge clk) begin
            if (rst) begin
                for (int a = 0; a < 16; a++) mem[a] <= init_word(a);
            end else if (!csn[g] && !wrnm[g]) begin
                mem[addrm[g]] <= wrdtm[g];
            end
            dly[0] <= (!csn[g] && wrnm[g]) ? mem[addrm[g]] : 16'($urandom);
            for (int k = 1; k < int'(LAT); k++) dly[k] <= dly[k-1];
        end
        assign rdin[g] = dly[LAT-1];
    end

    // Reference model state, per instance
    int          m_mode [NI];
    int          m_ptr [NI];
    logic [15:0] m_mem [NI][16];
    logic        e_csn [NI];
    logic        e_wrn [NI];
    logic [3:0]  e_addr [NI];
    logic [15:0] e_wrdt [NI];
    logic [15:0] e_rddt [NI];
    int          slot_ch [NI][16];
    logic [15:0] slot_dt [NI][16];
    int          last_due [NI];
    logic [2:0]  m_gnt [NI];

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] cycle %0d: observed %h expected %h",
                    tag, inst, cyc, obs, exp);
    endtask

    task automatic rand_data();
        addr = 12'($urandom);
        wrdt = {16'($urandom), 32'($urandom)};
    endtask

    // One clock cycle: check every instance against the model, advance the model
    task automatic step(input bit do_chk);
        logic [2:0] elig;
        logic [2:0] cand;
        logic [2:0] ev;
        int k;
        int c;
        int s;
        int due;
        int a;
        #1;
        for (int i = 0; i < NI; i++) begin
            elig = 3'b000;
            if (!rst && m_mode[i] == M_NORM && !flag) elig = 3'b111;
            if (!rst && m_mode[i] == M_UPD && flag) elig = 3'b001;
            cand = req & elig;
            k = -1;
            for (int j = 0; j < 3; j++) begin
                c = (i == 1) ? j : (m_ptr[i] + j) % 3;
                if (k < 0 && cand[c]) k = c;
            end
            m_gnt[i] = (k >= 0) ? 3'(1 << k) : 3'b000;
            s = cyc % 16;
            ev = (slot_ch[i][s] >= 0) ? 3'(1 << slot_ch[i][s]) : 3'b000;
            if (slot_ch[i][s] >= 0) e_rddt[i] = slot_dt[i][s];
            slot_ch[i][s] = -1;
            if (do_chk) begin
                chk("gnt", i, 32'(gnt[i]), 32'(m_gnt[i]));
                chk("csn", i, 32'(csn[i]), 32'(e_csn[i]));
                chk("wrn", i, 32'(wrnm[i]), 32'(e_wrn[i]));
                chk("addr", i, 32'(addrm[i]), 32'(e_addr[i]));
                chk("wrdt", i, 32'(wrdtm[i]), 32'(e_wrdt[i]));
                chk("rdvld", i, 32'(rdvld[i]), 32'(ev));
                chk("rddt", i, 32'(rddt[i]), 32'(e_rddt[i]));
                chk("busy", i, 32'(busy[i]), 32'(m_mode[i] != M_NORM));
            end
            if (rst) begin
                m_mode[i] = M_NORM;
                m_ptr[i] = 0;
                e_csn[i] = 1'b1;
                e_wrn[i] = 1'b1;
                e_addr[i] = '0;
                e_wrdt[i] = '0;
                e_rddt[i] = '0;
                last_due[i] = 0;
                for (int j = 0; j < 16; j++) begin
                    slot_ch[i][j] = -1;
                    m_mem[i][j] = init_word(j);
                end
            end else begin
                e_csn[i] = (k < 0);
                e_wrn[i] = (k < 0) ? 1'b1 : wrn[k];
                if (k >= 0) begin
                    a = int'(addr[k*4 +: 4]);
                    e_addr[i] = addr[k*4 +: 4];
                    e_wrdt[i] = wrdt[k*16 +: 16];
                    if (wrn[k]) begin
                        due = cyc + 2 + lat_of(i);
                        slot_ch[i][due % 16] = k;
                        slot_dt[i][due % 16] = m_mem[i][a];
                        last_due[i] = due;
                    end else begin
                        m_mem[i][a] = wrdt[k*16 +: 16];
                    end
                    if (i != 1 && m_mode[i] == M_NORM) m_ptr[i] = (k + 1) % 3;
                end
                case (m_mode[i])
                    M_NORM:  if (flag) m_mode[i] = M_DRAIN;
                    M_DRAIN: begin
                        if (!flag) m_mode[i] = M_NORM;
                        else if (last_due[i] <= cyc) m_mode[i] = M_UPD;
                    end
                    default: if (!flag) m_mode[i] = M_NORM;
                endcase
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_exp [6];
        int cnt;
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst = 1'b1; flag = 1'b0; req = 3'b111; wrn = 3'b111;
        rand_data();
        @(negedge clk);
        step(1'b0);
        step(1'b1);

        // All channels reading: rotation in RR, channel 0 always in fixed priority
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            rand_data();
            #1;
            chk("rr_seq", 0, 32'(gnt[0]), 32'(rr_exp[t]));
            chk("fp_ch0", 1, 32'(gnt[1]), 32'(3'b001));
            step(1'b1);
        end

        req = 3'b110;
        for (int t = 0; t < 4; t++) begin
            rand_data();
            #1;
            chk("fp_ch1", 1, 32'(gnt[1]), 32'(3'b010));
            step(1'b1);
        end
        req = 3'b100;
        rand_data();
        #1;
        chk("fp_ch2", 1, 32'(gnt[1]), 32'(3'b100));
        step(1'b1);
        req = 3'b000;
        for (int t = 0; t < 5; t++) step(1'b1);

        // Channel 2 reads address A, then writes address 3
        req = 3'b100;
        rand_data();
        addr[11:8] = 4'hA;
        step(1'b1);
        req = 3'b000;
        step(1'b1);
        step(1'b1);
        #1;
        chk("rd_ret_vld", 0, 32'(rdvld[0]), 32'(3'b100));
        chk("rd_ret_dt", 0, 32'(rddt[0]), 32'(16'h1234));
        step(1'b1);
        req = 3'b100; wrn = 3'b011;
        rand_data();
        addr[11:8] = 4'h3;
        step(1'b1);
        req = 3'b000; wrn = 3'b111;
        for (int t = 0; t < 6; t++) step(1'b1);

        // Update drain: ch1 read in flight, flag rises, ch0 writes 16 words
        req = 3'b010;
        rand_data();
        step(1'b1);
        flag = 1'b1; req = 3'b101; wrn = 3'b110;
        cnt = 0;
        for (int t = 0; t < 60 && cnt < 16; t++) begin
            rand_data();
            addr[3:0] = 4'(cnt);
            step(1'b1);
            if (m_gnt[2][0]) cnt++;
        end
        chk("upd_writes", 2, 32'(cnt), 32'(16));
        flag = 1'b0; wrn = 3'b111; req = 3'b100;
        step(1'b1);
        #1;
        chk("ch2_after_upd", 2, 32'(gnt[2]), 32'(3'b100));
        step(1'b1);
        req = 3'b000;
        for (int t = 0; t < 6; t++) step(1'b1);

        // One-cycle flag pulse while a read is still in flight
        req = 3'b010;
        step(1'b1);
        req = 3'b000; flag = 1'b1;
        step(1'b1);
        flag = 1'b0;
        #1;
        chk("pulse_busy", 2, 32'(busy[2]), 32'(1));
        step(1'b1);
        #1;
        chk("pulse_norm", 2, 32'(busy[2]), 32'(0));
        for (int t = 0; t < 6; t++) step(1'b1);

        // Reset with a read in flight must drop its return
        req = 3'b001;
        step(1'b1);
        req = 3'b000; rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) step(1'b1);

        // Random traffic with occasional update windows and resets
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) flag = ~flag;
            req = 3'($urandom);
            wrn = 3'($urandom);
            rand_data();
            step(1'b1);
        end
        rst = 1'b0; flag = 1'b0; req = 3'b000;
        for (int t = 0; t < 8; t++) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
